sram_avalon_bridge: RTL and testbench

Parametrised Avalon-MM slave that drives an external asynchronous SRAM: DQ, ADDR, byte strobes, WE_n, CE_n and OE_n. It replaces the fixed 16-bit SRAM conduit on the Nios system. It adds a host data width that is a multiple of the SRAM width, programmable read/write wait states, a bus-turnaround gap, and sequencing that skips empty beats. It sits between the Qsys interconnect and the board SRAM pins.

---
 rtl/sram_avalon_pkg.sv | 45 ++++
 rtl/sram_dq_io.sv | 48 ++++
 rtl/sram_avalon_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_sram_avalon_bridge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_avalon_pkg.sv
// Shared types and elaboration helpers for the Avalon-MM to async SRAM bridge.
package sram_avalon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_TURN
  } state_e;

  localparam int unsigned SRAM_DW_DEF    = 16;
  localparam int unsigned SRAM_AW_DEF    = 20;
  localparam int unsigned BEATS_DEF      = 1;
  localparam int unsigned RD_WAIT_DEF    = 1;
  localparam int unsigned WR_WAIT_DEF    = 1;
  localparam int unsigned TURNAROUND_DEF = 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Beat index width, kept at least 1 bit so single-beat builds stay legal
  function automatic int unsigned beat_bits(input int unsigned beats);
    return (beats > 1) ? clog2(beats) : 1;
  endfunction

  function automatic int unsigned cnt_bits(input int unsigned max_cnt);
    return (max_cnt > 0) ? clog2(max_cnt + 1) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_dq_io.sv
// SRAM DQ pad: registered output enable/data and per-beat read capture.
module sram_dq_io
  import sram_avalon_pkg::*;
#(
  parameter int unsigned SRAM_DW = SRAM_DW_DEF,
  parameter int unsigned BEATS   = BEATS_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          oe_d,
  input  logic [SRAM_DW-1:0]            dout_d,
  input  logic                          cap_en,
  input  logic [beat_bits(BEATS)-1:0]   cap_sel,
  output logic [SRAM_DW*BEATS-1:0]      rdata,
  inout  wire  [SRAM_DW-1:0]            dq
);

  localparam int unsigned HDW = SRAM_DW * BEATS;
  localparam int unsigned BIW = beat_bits(BEATS);

  logic               oe_q;
  logic [SRAM_DW-1:0] dout_q;
  logic [HDW-1:0]     rdata_q, rdata_d;

  assign dq    = oe_q ? dout_q : {SRAM_DW{1'bz}};
  assign rdata = rdata_q;

  // Drop the sampled pin value into the slice of the beat being read
  always_comb begin
    rdata_d = rdata_q;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (cap_en && cap_sel == BIW'(b)) rdata_d[b*SRAM_DW +: SRAM_DW] = dq;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/sram_avalon_bridge.sv
// Avalon-MM slave sequencing host words into one or more async SRAM beats.
module sram_avalon_bridge
  import sram_avalon_pkg::*;
#(
  parameter int unsigned SRAM_DW    = SRAM_DW_DEF,
  parameter int unsigned SRAM_AW    = SRAM_AW_DEF,
  parameter int unsigned BEATS      = BEATS_DEF,
  parameter int unsigned RD_WAIT    = RD_WAIT_DEF,
  parameter int unsigned WR_WAIT    = WR_WAIT_DEF,
  parameter int unsigned TURNAROUND = TURNAROUND_DEF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [SRAM_AW-clog2(BEATS)-1:0]     avs_address,
  input  logic                                avs_read,
  input  logic                                avs_write,
  input  logic [SRAM_DW*BEATS-1:0]            avs_writedata,
  input  logic [SRAM_DW*BEATS/8-1:0]          avs_byteenable,
  output logic                                avs_waitrequest,
  output logic [SRAM_DW*BEATS-1:0]            avs_readdata,
  output logic                                avs_readdatavalid,
  inout  wire  [SRAM_DW-1:0]                  sram_DQ,
  output logic [SRAM_AW-1:0]                  sram_ADDR,
  output logic [SRAM_DW/8-1:0]                sram_BE_n,
  output logic                                sram_WE_n,
  output logic                                sram_CE_n,
  output logic                                sram_OE_n
);

  localparam int unsigned HDW = SRAM_DW * BEATS;
  localparam int unsigned BEW = HDW / 8;
  localparam int unsigned SBW = SRAM_DW / 8;
  localparam int unsigned LBW = clog2(BEATS);
  localparam int unsigned BIW = beat_bits(BEATS);
  localparam int unsigned HAW = SRAM_AW - LBW;
  localparam int unsigned CW  = cnt_bits(max3(RD_WAIT, WR_WAIT, TURNAROUND));

  state_e             state_q, state_d;
  logic [HAW-1:0]     addr_q, addr_d;
  logic [HDW-1:0]     wdata_q, wdata_d;
  logic [BEW-1:0]     be_q, be_d;
  logic [BIW-1:0]     beat_q, beat_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SBW-1:0]     be_n_q, be_n_d;
  logic               we_n_q, we_n_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               rdv_q, rdv_d;
  logic               dq_oe_d;
  logic [SRAM_DW-1:0] dq_out_d;
  logic               cap_en;
  logic [BIW:0]       hit;

  // Lowest beat at or above 'from' with any byte enabled, as {found, index}
  function automatic logic [BIW:0] find_beat(input logic [BEW-1:0] be, input int unsigned from);
    logic [BIW:0] r;
    r = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (!r[BIW] && i >= from && |be[i*SBW +: SBW]) r = {1'b1, BIW'(i)};
    end
    return r;
  endfunction

  // With a single beat the index bit is shifted back out of the address
  function automatic logic [SRAM_AW-1:0] mk_addr(input logic [HAW-1:0] a, input logic [BIW-1:0] b);
    return SRAM_AW'({a, b} >> (BIW - LBW));
  endfunction

  function automatic logic [SBW-1:0] be_slice(input logic [BEW-1:0] be, input logic [BIW-1:0] b);
    return be[int'(b)*SBW +: SBW];
  endfunction

  function automatic logic [SRAM_DW-1:0] w_slice(input logic [HDW-1:0] w, input logic [BIW-1:0] b);
    return w[int'(b)*SRAM_DW +: SRAM_DW];
  endfunction

  // Pin values are computed for the state being entered so they register in step with it
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    be_n_d      = '1;
    we_n_d      = 1'b1;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    rdv_d       = 1'b0;
    dq_oe_d     = 1'b0;
    dq_out_d    = '0;
    cap_en      = 1'b0;
    hit         = '0;

    case (state_q)
      ST_IDLE: begin
        if (avs_write) begin
          addr_d  = avs_address;
          wdata_d = avs_writedata;
          be_d    = avs_byteenable;
          hit     = find_beat(avs_byteenable, 0);
          if (hit[BIW]) begin
            state_d     = ST_WR_SETUP;
            beat_d      = hit[BIW-1:0];
            cnt_d       = '0;
            sram_addr_d = mk_addr(avs_address, hit[BIW-1:0]);
            ce_n_d      = 1'b0;
            be_n_d      = ~be_slice(avs_byteenable, hit[BIW-1:0]);
            dq_oe_d     = 1'b1;
            dq_out_d    = w_slice(avs_writedata, hit[BIW-1:0]);
          end
        end else if (avs_read) begin
          state_d     = ST_RD_ACC;
          addr_d      = avs_address;
          beat_d      = '0;
          cnt_d       = '0;
          sram_addr_d = mk_addr(avs_address, '0);
          ce_n_d      = 1'b0;
          oe_n_d      = 1'b0;
          be_n_d      = '0;
        end
      end

      ST_RD_ACC: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = '0;
        if (cnt_q == CW'(RD_WAIT)) begin
          cap_en = 1'b1;
          cnt_d  = '0;
          if (beat_q == BIW'(BEATS - 1)) begin
            rdv_d   = 1'b1;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            be_n_d  = '1;
            state_d = (TURNAROUND == 0) ? ST_IDLE : ST_TURN;
          end else begin
            beat_d      = beat_q + BIW'(1);
            sram_addr_d = mk_addr(addr_q, beat_q + BIW'(1));
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WR_SETUP: begin
        state_d  = ST_WR_PULSE;
        cnt_d    = '0;
        ce_n_d   = 1'b0;
        we_n_d   = 1'b0;
        be_n_d   = ~be_slice(be_q, beat_q);
        dq_oe_d  = 1'b1;
        dq_out_d = w_slice(wdata_q, beat_q);
      end

      ST_WR_PULSE: begin
        ce_n_d   = 1'b0;
        be_n_d   = ~be_slice(be_q, beat_q);
        dq_oe_d  = 1'b1;
        dq_out_d = w_slice(wdata_q, beat_q);
        if (cnt_q == CW'(WR_WAIT)) begin
          state_d = ST_WR_HOLD;
        end else begin
          we_n_d = 1'b0;
          cnt_d  = cnt_q + CW'(1);
        end
      end

      ST_WR_HOLD: begin
        hit = find_beat(be_q, 32'(beat_q) + 32'd1);
        if (hit[BIW]) begin
          state_d     = ST_WR_SETUP;
          beat_d      = hit[BIW-1:0];
          sram_addr_d = mk_addr(addr_q, hit[BIW-1:0]);
          ce_n_d      = 1'b0;
          be_n_d      = ~be_slice(be_q, hit[BIW-1:0]);
          dq_oe_d     = 1'b1;
          dq_out_d    = w_slice(wdata_q, hit[BIW-1:0]);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TURN: begin
        if (cnt_q == CW'(TURNAROUND - 1)) state_d = ST_IDLE;
        else                              cnt_d   = cnt_q + CW'(1);
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      sram_addr_q <= '0;
      be_n_q      <= '1;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      rdv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      be_n_q      <= be_n_d;
      we_n_q      <= we_n_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      rdv_q       <= rdv_d;
    end
  end

  sram_dq_io #(
    .SRAM_DW (SRAM_DW),
    .BEATS   (BEATS)
  ) u_dq_io (
    .clk     (clk),
    .reset_n (reset_n),
    .oe_d    (dq_oe_d),
    .dout_d  (dq_out_d),
    .cap_en  (cap_en),
    .cap_sel (beat_q),
    .rdata   (avs_readdata),
    .dq      (sram_DQ)
  );

  assign avs_waitrequest   = !(reset_n && state_q == ST_IDLE);
  assign avs_readdatavalid = rdv_q;
  assign sram_ADDR         = sram_addr_q;
  assign sram_BE_n         = be_n_q;
  assign sram_WE_n         = we_n_q;
  assign sram_CE_n         = ce_n_q;
  assign sram_OE_n         = oe_n_q;

endmodule

// File: tb/tb_sram_avalon_bridge.sv
// Directed bench: default single-beat bridge and a two-beat/two-turnaround bridge on SRAM models.
module tb_sram_avalon_bridge;

  logic clk;
  logic reset_n;

  // Single-beat instance (all defaults)
  logic        a_read, a_write, a_wait, a_rdv, a_we_n, a_ce_n, a_oe_n;
  logic [19:0] a_address, a_sram_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [1:0]  a_be, a_be_n;
  wire  [15:0] a_dq;

  // Two-beat instance, TURNAROUND=2
  logic        b_read, b_write, b_wait, b_rdv, b_we_n, b_ce_n, b_oe_n;
  logic [18:0] b_address;
  logic [19:0] b_sram_addr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic [1:0]  b_be_n;
  wire  [15:0] b_dq;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  int          a_wcnt = 0;
  int          b_wcnt = 0;
  logic [19:0] b_last_addr = '0;

  int n_chk  = 0;
  int n_pass = 0;

  sram_avalon_bridge u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .avs_address(a_address), .avs_read(a_read), .avs_write(a_write),
    .avs_writedata(a_wdata), .avs_byteenable(a_be),
    .avs_waitrequest(a_wait), .avs_readdata(a_rdata), .avs_readdatavalid(a_rdv),
    .sram_DQ(a_dq), .sram_ADDR(a_sram_addr), .sram_BE_n(a_be_n),
    .sram_WE_n(a_we_n), .sram_CE_n(a_ce_n), .sram_OE_n(a_oe_n)
  );

  sram_avalon_bridge #(.BEATS(2), .TURNAROUND(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .avs_address(b_address), .avs_read(b_read), .avs_write(b_write),
    .avs_writedata(b_wdata), .avs_byteenable(b_be),
    .avs_waitrequest(b_wait), .avs_readdata(b_rdata), .avs_readdatavalid(b_rdv),
    .sram_DQ(b_dq), .sram_ADDR(b_sram_addr), .sram_BE_n(b_be_n),
    .sram_WE_n(b_we_n), .sram_CE_n(b_ce_n), .sram_OE_n(b_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM models: drive DQ on an output-enabled read, write on WE_n rising
  assign a_dq = (a_ce_n == 1'b0 && a_oe_n == 1'b0 && a_we_n == 1'b1) ? mem_a[a_sram_addr[7:0]] : 16'bz;
  assign b_dq = (b_ce_n == 1'b0 && b_oe_n == 1'b0 && b_we_n == 1'b1) ? mem_b[b_sram_addr[7:0]] : 16'bz;

  always @(posedge a_we_n) begin
    if (reset_n === 1'b1 && a_ce_n === 1'b0) begin
      if (!a_be_n[0]) mem_a[a_sram_addr[7:0]][7:0]  = a_dq[7:0];
      if (!a_be_n[1]) mem_a[a_sram_addr[7:0]][15:8] = a_dq[15:8];
      a_wcnt++;
    end
  end

  always @(posedge b_we_n) begin
    if (reset_n === 1'b1 && b_ce_n === 1'b0) begin
      if (!b_be_n[0]) mem_b[b_sram_addr[7:0]][7:0]  = b_dq[7:0];
      if (!b_be_n[1]) mem_b[b_sram_addr[7:0]][15:8] = b_dq[15:8];
      b_last_addr = b_sram_addr;
      b_wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_a_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (a_wait && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_timeout", 32'(a_wait), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_read = 0; a_write = 0; a_address = '0; a_wdata = '0; a_be = '0;
    b_read = 0; b_write = 0; b_address = '0; b_wdata = '0; b_be = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_wait",   32'(a_wait), 32'd1);
    chk("rst_ce_n",   32'(a_ce_n), 32'd1);
    chk("rst_oe_n",   32'(a_oe_n), 32'd1);
    chk("rst_we_n",   32'(a_we_n), 32'd1);
    chk("rst_be_n",   32'(a_be_n), 32'h3);
    chk("rst_addr",   32'(a_sram_addr), 32'h0);
    chk("rst_rdv",    32'(a_rdv), 32'd0);
    chk("rst_rdata",  32'(a_rdata), 32'h0);
    chk("rst_b_be_n", 32'(b_be_n), 32'h3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_wait", 32'(a_wait), 32'd0);

    // Single-beat write 0x1234 -> 0x00010
    a_write = 1; a_address = 20'h00010; a_wdata = 16'h1234; a_be = 2'b11;
    @(negedge clk);
    a_write = 0;
    chk("w_setup_ce", 32'(a_ce_n), 32'd0);
    chk("w_setup_we", 32'(a_we_n), 32'd1);
    chk("w_setup_oe", 32'(a_oe_n), 32'd1);
    chk("w_setup_addr", 32'(a_sram_addr), 32'h10);
    chk("w_setup_dq", 32'(a_dq), 32'h1234);
    chk("w_setup_wait", 32'(a_wait), 32'd1);
    @(negedge clk);
    chk("w_pulse1_we", 32'(a_we_n), 32'd0);
    chk("w_pulse1_be", 32'(a_be_n), 32'h0);
    @(negedge clk);
    chk("w_pulse2_we", 32'(a_we_n), 32'd0);
    @(negedge clk);
    chk("w_hold_we", 32'(a_we_n), 32'd1);
    chk("w_hold_ce", 32'(a_ce_n), 32'd0);
    chk("w_hold_dq", 32'(a_dq), 32'h1234);
    @(negedge clk);
    chk("w_done_wait", 32'(a_wait), 32'd0);
    chk("w_done_ce", 32'(a_ce_n), 32'd1);
    chk("w_mem", 32'(mem_a[8'h10]), 32'h1234);
    chk("w_cnt", 32'(a_wcnt), 32'd1);

    // Read back 0x00010
    a_read = 1; a_address = 20'h00010;
    @(negedge clk);
    a_read = 0;
    chk("r_acc_ce", 32'(a_ce_n), 32'd0);
    chk("r_acc_oe", 32'(a_oe_n), 32'd0);
    chk("r_acc_we", 32'(a_we_n), 32'd1);
    chk("r_acc_rdv0", 32'(a_rdv), 32'd0);
    @(negedge clk);
    chk("r_acc_rdv1", 32'(a_rdv), 32'd0);
    @(negedge clk);
    chk("r_rdv", 32'(a_rdv), 32'd1);
    chk("r_data", 32'(a_rdata), 32'h1234);
    chk("r_turn_wait", 32'(a_wait), 32'd1);
    chk("r_turn_oe", 32'(a_oe_n), 32'd1);
    @(negedge clk);
    chk("r_rdv_pulse", 32'(a_rdv), 32'd0);
    chk("r_idle_wait", 32'(a_wait), 32'd0);

    // Write with no byte enables touches no pins
    a_write = 1; a_address = 20'h00030; a_wdata = 16'hFFFF; a_be = 2'b00;
    @(negedge clk);
    a_write = 0;
    chk("be0_wait", 32'(a_wait), 32'd0);
    chk("be0_ce", 32'(a_ce_n), 32'd1);
    chk("be0_we", 32'(a_we_n), 32'd1);
    @(negedge clk);
    chk("be0_cnt", 32'(a_wcnt), 32'd1);

    // Read and write together: the write wins
    a_read = 1; a_write = 1; a_address = 20'h00020; a_wdata = 16'h5555; a_be = 2'b11;
    @(negedge clk);
    a_read = 0; a_write = 0;
    chk("rw_oe", 32'(a_oe_n), 32'd1);
    chk("rw_ce", 32'(a_ce_n), 32'd0);
    wait_a_idle(20);
    chk("rw_mem", 32'(mem_a[8'h20]), 32'h5555);
    chk("rw_no_rdv", 32'(a_rdv), 32'd0);

    // Reset in the middle of a read, then a clean read
    a_read = 1; a_address = 20'h00010;
    @(negedge clk);
    a_read = 0;
    chk("ab_ce", 32'(a_ce_n), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("ab_ce_rst", 32'(a_ce_n), 32'd1);
    chk("ab_oe_rst", 32'(a_oe_n), 32'd1);
    chk("ab_be_rst", 32'(a_be_n), 32'h3);
    chk("ab_rdv_rst", 32'(a_rdv), 32'd0);
    chk("ab_wait_rst", 32'(a_wait), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ab_rdv_after", 32'(a_rdv), 32'd0);
    chk("ab_rdata_clr", 32'(a_rdata), 32'h0);
    chk("ab_wait_after", 32'(a_wait), 32'd0);
    a_read = 1; a_address = 20'h00020;
    @(negedge clk);
    a_read = 0;
    chk("ar_rdv0", 32'(a_rdv), 32'd0);
    @(negedge clk);
    chk("ar_rdv1", 32'(a_rdv), 32'd0);
    @(negedge clk);
    chk("ar_rdv", 32'(a_rdv), 32'd1);
    chk("ar_data", 32'(a_rdata), 32'h5555);

    // Two-beat write 0xDEADBEEF -> host 0x8 (SRAM 0x10, 0x11)
    @(negedge clk);
    b_write = 1; b_address = 19'h8; b_wdata = 32'hDEADBEEF; b_be = 4'hF;
    @(negedge clk);
    b_write = 0;
    chk("b_w0_addr", 32'(b_sram_addr), 32'h10);
    chk("b_w0_dq", 32'(b_dq), 32'hBEEF);
    @(negedge clk);
    chk("b_w0_we", 32'(b_we_n), 32'd0);
    chk("b_w0_be", 32'(b_be_n), 32'h0);
    repeat (2) @(negedge clk);
    chk("b_w0_hold_addr", 32'(b_sram_addr), 32'h10);
    chk("b_w0_hold_we", 32'(b_we_n), 32'd1);
    @(negedge clk);
    chk("b_w1_addr", 32'(b_sram_addr), 32'h11);
    chk("b_w1_dq", 32'(b_dq), 32'hDEAD);
    chk("b_w1_ce", 32'(b_ce_n), 32'd0);
    repeat (4) @(negedge clk);
    chk("b_w_wait", 32'(b_wait), 32'd0);
    chk("b_mem10", 32'(mem_b[8'h10]), 32'hBEEF);
    chk("b_mem11", 32'(mem_b[8'h11]), 32'hDEAD);

    // Two-beat readback, then a write queued behind the turnaround
    b_read = 1; b_address = 19'h8;
    @(negedge clk);
    b_read = 0;
    chk("b_r_addr0", 32'(b_sram_addr), 32'h10);
    repeat (2) @(negedge clk);
    chk("b_r_addr1", 32'(b_sram_addr), 32'h11);
    chk("b_r_rdv_early", 32'(b_rdv), 32'd0);
    repeat (2) @(negedge clk);
    chk("b_r_rdv", 32'(b_rdv), 32'd1);
    chk("b_r_data", b_rdata, 32'hDEADBEEF);
    chk("b_turn1_oe", 32'(b_oe_n), 32'd1);
    b_write = 1; b_address = 19'h9; b_wdata = 32'h0000_7777; b_be = 4'b0011;
    @(negedge clk);
    chk("b_turn2_wait", 32'(b_wait), 32'd1);
    chk("b_turn2_oe", 32'(b_oe_n), 32'd1);
    chk("b_turn2_ce", 32'(b_ce_n), 32'd1);
    @(negedge clk);
    chk("b_idle_wait", 32'(b_wait), 32'd0);
    chk("b_idle_oe", 32'(b_oe_n), 32'd1);
    @(negedge clk);
    b_write = 0;
    chk("b_b2b_ce", 32'(b_ce_n), 32'd0);
    chk("b_b2b_addr", 32'(b_sram_addr), 32'h12);
    chk("b_b2b_dq", 32'(b_dq), 32'h7777);
    repeat (4) @(negedge clk);
    chk("b_b2b_wait", 32'(b_wait), 32'd0);
    chk("b_b2b_mem", 32'(mem_b[8'h12]), 32'h7777);
    chk("b_b2b_cnt", 32'(b_wcnt), 32'd3);

    // Upper-half-only write: beat 0 is skipped
    b_write = 1; b_address = 19'hA; b_wdata = 32'hABCD_0000; b_be = 4'b1100;
    @(negedge clk);
    b_write = 0;
    chk("b_skip_addr", 32'(b_sram_addr), 32'h15);
    chk("b_skip_dq", 32'(b_dq), 32'hABCD);
    @(negedge clk);
    chk("b_skip_be", 32'(b_be_n), 32'h0);
    chk("b_skip_we", 32'(b_we_n), 32'd0);
    repeat (2) @(negedge clk);
    chk("b_skip_hold_wait", 32'(b_wait), 32'd1);
    @(negedge clk);
    chk("b_skip_wait", 32'(b_wait), 32'd0);
    chk("b_skip_cnt", 32'(b_wcnt), 32'd4);
    chk("b_skip_last", 32'(b_last_addr), 32'h15);
    chk("b_skip_mem", 32'(mem_b[8'h15]), 32'hABCD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
